// File: rtl/fifo_write_arbiter.sv
// Round-robin, credit-based scheduler sharing one FIFO write port between NREQ producers.
// Latency: one cycle from an accepted transfer edge to FIFO_WR/FIFO_DIN.
// Backpressure: ACK is withheld when credits are exhausted, QUEUE_FULL is high or RST is high.
//
// Ports:
//   CLK, RST          clock (rising edge), synchronous active-high reset
//   REQ, DIN_ARR      per-producer valid and data (producer i at bits [i*DW +: DW])
//   ACK               combinational one-hot ready; REQ[i]&ACK[i] at an edge is a transfer
//   FIFO_WR, FIFO_DIN registered write strobe and data towards the FIFO
//   QUEUE_FULL, POP   FIFO full inhibit and one-pulse-per-read credit return
//   OWNER, BUSY       current/last owner index, burst in progress
//   CREDIT_CNT        free FIFO entries as seen by the scheduler
module fifo_write_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 16,
    parameter int CREDITS   = 31,
    parameter int MAX_BURST = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NREQ-1:0]              REQ,
    input  logic [NREQ*DW-1:0]           DIN_ARR,
    output logic [NREQ-1:0]              ACK,
    output logic                         FIFO_WR,
    output logic [DW-1:0]                FIFO_DIN,
    input  logic                         QUEUE_FULL,
    input  logic                         POP,
    output logic [$clog2(NREQ)-1:0]      OWNER,
    output logic                         BUSY,
    output logic [$clog2(CREDITS+1)-1:0] CREDIT_CNT
);

    localparam int OW = $clog2(NREQ);
    localparam int CW = $clog2(CREDITS + 1);
    localparam int BW = $clog2(MAX_BURST + 1);

    localparam logic [CW-1:0] CRED_MAX  = CW'(CREDITS);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state;
    logic [BW-1:0]   burst_cnt;
    logic            can_issue;
    logic            win_vld;
    logic [OW-1:0]   win_idx;
    logic [OW-1:0]   sel;
    logic [DW-1:0]   din_sel;
    logic            xfer;

    assign can_issue = (CREDIT_CNT != '0) && !QUEUE_FULL && !RST;
    assign BUSY      = (state == BURST);

    // First requester after the current owner, wrapping modulo NREQ; the owner
    // itself is searched last so it only wins again when nobody else asks.
    always_comb begin
        logic [OW-1:0] idx;
        win_vld = 1'b0;
        win_idx = '0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = OW'((int'(OWNER) + k) % NREQ);
            if (!win_vld && REQ[idx]) begin
                win_vld = 1'b1;
                win_idx = idx;
            end
        end
    end

    // Only IDLE arbitrates; BURST serves the owner alone, so changing owner
    // always costs one bubble cycle. The burst limit check keeps the last
    // BURST cycle idle, which is what gives that bubble after a full burst.
    always_comb begin
        ACK = '0;
        sel = OWNER;
        if (state == IDLE) begin
            sel = win_idx;
            if (can_issue && win_vld)
                ACK[win_idx] = 1'b1;
        end else begin
            if (REQ[OWNER] && can_issue && (burst_cnt < BURST_MAX))
                ACK[OWNER] = 1'b1;
        end
    end

    assign xfer = |(REQ & ACK);

    always_comb begin
        din_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel == OW'(i))
                din_sel = DIN_ARR[i*DW +: DW];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            OWNER      <= OW'(NREQ - 1);
            CREDIT_CNT <= CRED_MAX;
            FIFO_WR    <= 1'b0;
            FIFO_DIN   <= '0;
        end else begin
            FIFO_WR <= xfer;
            if (xfer)
                FIFO_DIN <= din_sel;

            // A pop against a full credit pool is a consumer bug; saturate.
            case ({xfer, POP})
                2'b10:   CREDIT_CNT <= CREDIT_CNT - 1'b1;
                2'b01:   if (CREDIT_CNT != CRED_MAX) CREDIT_CNT <= CREDIT_CNT + 1'b1;
                default: CREDIT_CNT <= CREDIT_CNT;
            endcase

            case (state)
                IDLE: begin
                    if (xfer) begin
                        OWNER     <= win_idx;
                        burst_cnt <= BW'(1);
                        state     <= BURST;
                    end
                end
                BURST: begin
                    // Any cycle without a transfer (owner dropped REQ, limit
                    // reached, or issue blocked) ends the burst.
                    if (xfer)
                        burst_cnt <= burst_cnt + 1'b1;
                    else
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_pop_overflow: assert property (@(posedge CLK) disable iff (RST)
        !(POP && (CREDIT_CNT == CRED_MAX)));

endmodule
